// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide unit with BUSY/DONE handshake and flush abort.
// Define FAST_MUL_EN for single-cycle multiplies; divides always iterate.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [4:0]      i_alu_ctrl,
    input  logic [XLEN-1:0] i_operand1,
    input  logic [XLEN-1:0] i_operand2,
    input  logic            i_flush,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy,
    output logic            o_done
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_result, r_hi, r_lo, r_m;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_op;
    logic            r_neg;

    logic [2:0]      w_op;
    logic            w_valid, w_sa, w_sb, w_neg, w_dz, w_ov, w_ge;
    logic [XLEN-1:0] w_ma, w_mb, w_special, w_diff, w_hi_n, w_lo_n;
    logic [XLEN:0]   w_sum, w_sh;

    // op index 0..7 = MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU; bit 2 marks divides
    function automatic logic [XLEN-1:0] fmt(input logic [2:0] op, input logic neg,
                                            input logic [XLEN-1:0] hi, input logic [XLEN-1:0] lo);
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   v;
        p = neg ? -{hi, lo} : {hi, lo};
        v = op[1] ? hi : lo;
        return op[2] ? (neg ? -v : v) : (op == 3'd0 ? p[XLEN-1:0] : p[2*XLEN-1:XLEN]);
    endfunction

    assign w_op      = 3'(i_alu_ctrl - 5'd10);
    assign w_valid   = i_alu_ctrl >= 5'd10 && i_alu_ctrl <= 5'd17;
    assign w_sa      = i_operand1[XLEN-1] && (w_op == 3'd1 || w_op == 3'd2 || w_op == 3'd4 || w_op == 3'd6);
    assign w_sb      = i_operand2[XLEN-1] && (w_op == 3'd1 || w_op == 3'd4 || w_op == 3'd6);
    assign w_neg     = w_op == 3'd6 ? w_sa : w_sa ^ w_sb;
    assign w_ma      = w_sa ? -i_operand1 : i_operand1;
    assign w_mb      = w_sb ? -i_operand2 : i_operand2;
    assign w_dz      = w_op[2] && i_operand2 == '0;
    assign w_ov      = w_op[2] && !w_op[0] && i_operand1 == {1'b1, {(XLEN-1){1'b0}}} && i_operand2 == '1;
    assign w_special = w_dz ? (w_op[1] ? i_operand1 : '1) : (w_op[1] ? '0 : i_operand1);

    // one shift-add (multiply) or restoring-subtract (divide) step
    assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
    assign w_sh   = {r_hi, r_lo[XLEN-1]};
    assign w_ge   = w_sh >= {1'b0, r_m};
    assign w_diff = w_sh[XLEN-1:0] - r_m;
    assign w_hi_n = r_op[2] ? (w_ge ? w_diff : w_sh[XLEN-1:0]) : w_sum[XLEN:1];
    assign w_lo_n = r_op[2] ? {r_lo[XLEN-2:0], w_ge} : {w_sum[0], r_lo[XLEN-1:1]};

`ifdef FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast;
    assign w_fast = {{XLEN{1'b0}}, w_ma} * {{XLEN{1'b0}}, w_mb};
`endif

    assign o_result = r_result;
    assign o_busy   = r_state != S_IDLE;
    assign o_done   = r_state == S_FIN && !i_flush;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_m      <= '0;
            r_op     <= '0;
            r_neg    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start && !i_flush && w_valid) begin
                    r_op  <= w_op;
                    r_neg <= w_neg;
                    r_cnt <= '0;
                    r_hi  <= '0;
                    r_lo  <= w_op[2] ? w_ma : w_mb;
                    r_m   <= w_op[2] ? w_mb : w_ma;
                    if (w_dz || w_ov) begin
                        r_result <= w_special;
                        r_state  <= S_FIN;
                    end
`ifdef FAST_MUL_EN
                    else if (!w_op[2]) begin
                        r_result <= fmt(w_op, w_neg, w_fast[2*XLEN-1:XLEN], w_fast[XLEN-1:0]);
                        r_state  <= S_FIN;
                    end
`endif
                    else r_state <= S_RUN;
                end
                S_RUN: if (i_flush) r_state <= S_IDLE;
                else begin
                    r_hi  <= w_hi_n;
                    r_lo  <= w_lo_n;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(XLEN - 1)) begin
                        r_result <= fmt(r_op, r_neg, w_hi_n, w_lo_n);
                        r_state  <= S_FIN;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    localparam int XLEN = 32;
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
    logic [4:0]  ctrl = '0;
    logic [31:0] op1 = '0, op2 = '0, result;
    logic        busy, done;
    int          n_checks = 0, n_errors = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_alu_ctrl(ctrl),
        .i_operand1(op1), .i_operand2(op2), .i_flush(flush),
        .o_result(result), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        bit ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = a == MIN && b == 32'hFFFF_FFFF;
        case (c)
            5'd10: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            5'd11: begin p = sa * sb; return p[63:32]; end
            5'd12: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            5'd13: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            5'd14: return b == 0 ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            5'd15: return b == 0 ? 32'hFFFF_FFFF : a / b;
            5'd16: return b == 0 ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: return b == 0 ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        if (c >= 5'd14 && (b == 0 || ((c == 5'd14 || c == 5'd16) && a == MIN && b == 32'hFFFF_FFFF)))
            return 1;
`ifdef FAST_MUL_EN
        if (c < 5'd14) return 1;
`endif
        return XLEN + 1;
    endfunction

    // Called in cycle 1 after an accepting edge; follows the op to DONE and into IDLE.
    task automatic wait_done(input string tag, input logic [31:0] exp, input int exp_cyc);
        int cyc = 1, idle_seen = 0;
        while (!done && cyc <= 80) begin
            if (!busy) idle_seen++;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_busy_gap"}, 32'(idle_seen), 32'd0);
        check({tag, "_result"}, result, exp);
        @(posedge clk); #1;
        check({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
        check({tag, "_result_hold"}, result, exp);
    endtask

    task automatic run_op(input string tag, input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; ctrl = c; op1 = a; op2 = b;
        @(posedge clk); #1;
        start = 1'b0; op1 = $urandom; op2 = $urandom;
        wait_done(tag, ref_model(c, a, b), ref_latency(c, a, b));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return MIN;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] prev;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_result", result, 32'd0);
        check("reset_busy_done", {30'd0, busy, done}, 32'd0);
        reset = 1'b0;

        run_op("mul", 5'd10, 32'd7, 32'hFFFF_FFFD);
        run_op("mulh", 5'd11, MIN, MIN);
        run_op("mulhu", 5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhsu", 5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div", 5'd14, 32'hFFFF_FFF9, 32'd2);
        run_op("rem", 5'd16, 32'hFFFF_FFF9, 32'd2);
        run_op("divu", 5'd15, 32'd100, 32'd7);
        run_op("remu", 5'd17, 32'd100, 32'd7);
        run_op("div_by0", 5'd14, 32'd5, 32'd0);
        run_op("rem_by0", 5'd16, 32'd5, 32'd0);
        run_op("divu_by0", 5'd15, 32'd9, 32'd0);
        run_op("remu_by0", 5'd17, 32'd9, 32'd0);
        run_op("div_ovf", 5'd14, MIN, 32'hFFFF_FFFF);
        run_op("rem_ovf", 5'd16, MIN, 32'hFFFF_FFFF);

        // Unsupported code must not start anything.
        start = 1'b1; ctrl = 5'd2; op1 = 32'd3; op2 = 32'd4;
        @(posedge clk); #1;
        check("add_ignored", {30'd0, busy, done}, 32'd0);
        @(posedge clk); #1;
        check("add_ignored2", {30'd0, busy, done}, 32'd0);
        start = 1'b0;

        // FLUSH with START in IDLE: no accept.
        start = 1'b1; flush = 1'b1; ctrl = 5'd15; op1 = 32'd50; op2 = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_idle", {30'd0, busy, done}, 32'd0);

        // FLUSH during cycle 10 of a DIVU.
        prev = result;
        start = 1'b1; ctrl = 5'd15; op1 = 32'd1000; op2 = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i < 10; i++) begin @(posedge clk); #1; end
        flush = 1'b1;
        check("flush_busy_c10", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_idle_c11", {30'd0, busy, done}, 32'd0);
        check("flush_result_kept", result, prev);
        run_op("after_flush", 5'd15, 32'd1000, 32'd9);

        // RESET during cycle 5 of a DIV with START held.
        start = 1'b1; ctrl = 5'd14; op1 = 32'hFFFF_FF00; op2 = 32'd7;
        for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid_result", result, 32'd0);
        check("rst_mid_busy_done", {30'd0, busy, done}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        check("rst_restart_busy", {31'd0, busy}, 32'd1);
        wait_done("rst_restart", ref_model(5'd14, 32'hFFFF_FF00, 32'd7), XLEN + 1);

        for (int i = 0; i < 40; i++) begin
            logic [4:0] c;
            c = 5'($urandom_range(10, 17));
            run_op($sformatf("rnd%0d_op%0d", i, c), c, pick(), pick());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle RV32M multiply/divide execution unit, parametrised in operand width, driven by the 5-bit ALU control codes for MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. It sits in the EX stage beside the single-cycle ALU. It accepts one operation at a time and holds the pipeline via BUSY until a one-cycle DONE pulse presents the result. Pipeline flushes abort an operation in flight.

## Interface
- XLEN, 32: operand and result width; any even value ≥ 8.
- CLK  input  1  single clock, all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request; sampled only in IDLE.
- ALU_CTRL  input  5  operation code: 01010 MUL, 01011 MULH, 01100 MULHSU, 01101 MULHU, 01110 DIV, 01111 DIVU, 10000 REM, 10001 REMU.
- OPERAND1  input  XLEN  rs1 value (dividend / multiplicand).
- OPERAND2  input  XLEN  rs2 value (divisor / multiplier).
- FLUSH  input  1  abort in-flight operation, no DONE.
- RESULT  output  XLEN  registered result, held until the next completion.
- BUSY  output  1  high in RUN and FIN.
- DONE  output  1  one-cycle completion pulse, only in FIN.

## Operation
- States: IDLE, RUN, FIN. Reset: state IDLE, RESULT=0, BUSY=0, DONE=0, counter=0.
- Accept: in IDLE, START=1, FLUSH=0, ALU_CTRL in 01010..10001. Latch operands and op on that edge. START with any other code is ignored and the state stays IDLE.
- Signed handling: convert signed operands to magnitudes at accept. Record the result sign: MULH uses both operands signed; MULHSU uses OPERAND1 signed only; DIV uses the XOR of the signs; REM uses the sign of the dividend. Apply sign correction when loading RESULT.
- Multiply: 2·XLEN-bit product. MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits of the signed-corrected product.
- Divide: restoring, one quotient bit per RUN cycle, XLEN iterations.
- Divide by zero (OPERAND2=0): skip RUN and go straight to FIN. DIV/DIVU return all-ones; REM/REMU return OPERAND1.
- Signed overflow (DIV/REM, OPERAND1=most-negative, OPERAND2=−1): skip RUN. DIV returns OPERAND1; REM returns 0.
- RUN → FIN when the counter reaches XLEN−1. RESULT is loaded on the edge entering FIN.
- FIN → IDLE unconditionally. FIN has DONE=1, BUSY=1.
- FLUSH=1 in RUN or FIN: next state IDLE, DONE suppressed (a FLUSH in FIN gives DONE=0 that cycle's successor; DONE already high in FIN is combinational with state, so FLUSH in FIN gates DONE to 0), RESULT unchanged.
- FLUSH and START together in IDLE: FLUSH wins, no accept.
- RESET has priority over FLUSH and START in every state.

## Timing
- Cycle 0: accepting edge. Iterative ops are in RUN for cycles 1..XLEN, FIN at cycle XLEN+1, IDLE at XLEN+2.
- Special-case divides: FIN at cycle 1.
- A new START is accepted in the cycle after FIN, giving back-to-back throughput of one op per XLEN+2 cycles.
- Operands may change after accept without effect.
- RESULT is stable from FIN until the next FIN. BUSY=0 only in IDLE.

## Configuration
- FAST_MUL_EN defined: multiply ops compute the full product in one cycle and go IDLE → FIN directly, so DONE arrives at cycle 1. Divide is unchanged.
- FAST_MUL_EN undefined: multiply uses shift-add, one bit per RUN cycle, XLEN iterations, DONE at cycle XLEN+1, identical to divide.

## Test plan
- MUL, 7 × −3 (0xFFFFFFFD), XLEN=32 → RESULT 0xFFFFFFEB. DONE at cycle 33, or cycle 1 with FAST_MUL_EN.
- MULH, 0x80000000 × 0x80000000 → 0x40000000. MULHU, 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU, 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV, −7 ÷ 2 → 0xFFFFFFFD. REM, −7 ÷ 2 → 0xFFFFFFFF. DIVU, 100 ÷ 7 → 14. REMU, 100 ÷ 7 → 2. Each with DONE at cycle 33 and BUSY high for cycles 1..33.
- DIV with divisor 0 and dividend 5 → 0xFFFFFFFF, DONE at cycle 1. REM by 0 → 5. DIV 0x80000000 ÷ −1 → 0x80000000. REM of the same → 0.
- FLUSH at cycle 10 of a DIVU: IDLE at cycle 11, no DONE, RESULT keeps its prior value. A new START at cycle 11 completes normally.
- RESET at cycle 5 of a DIV with START held high: all outputs are 0 the next cycle, and the held START is accepted on the following edge. START with ALU_CTRL=00010 (ADD) → BUSY stays 0.
